regfile_wb_arbiter: RTL and testbench

- Writeback scheduler that shares the two register-file write ports between four result producers.
- Producers: ALU lane 0, ALU lane 1, load/store unit, multiply/divide unit.
- Each cycle it picks up to two requests in round-robin order and never issues two writes to the same register in one cycle.
- Its registered outputs drive WE1/WA1/WD1 and WE2/WA2/WD2 of the register file directly.

---
 rtl/regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// Writeback scheduler sharing the two register-file write ports between four
// result producers (ALU lane 0, ALU lane 1, LSU, MUL/DIV). Each cycle up to two
// nonzero-address requests are granted in round-robin order, never two to the
// same destination register. Requests for register 0 are sunk immediately and
// take no port slot. Grants register into WE1/WA1/WD1 (slot 1) and
// WE2/WA2/WD2 (slot 2), so an accepted result is written one cycle later.
//
// Optional feature: define REGFILE_WB_ARB_PERF_EN to add the 16-bit saturating
// perf_stall_cnt output, which counts cycles in which at least one valid
// nonzero-address request was held off.

module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   WE1,
  output logic [ADDR_W-1:0]      WA1,
  output logic [DATA_W-1:0]      WD1,
  output logic                   WE2,
  output logic [ADDR_W-1:0]      WA2,
  output logic [DATA_W-1:0]      WD2
`ifdef REGFILE_WB_ARB_PERF_EN
  ,
  output logic [15:0]            perf_stall_cnt
`endif
);

  // The round-robin pointer is exactly wide enough to wrap modulo NREQ (4).
  localparam int PTR_W = 2;

  // ---------------------------------------------------------------------------
  // Request unpacking
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];
  logic [NREQ-1:0]   zero_addr;   // valid request aimed at register 0
  logic [NREQ-1:0]   valid_nz;    // valid request that needs a port slot

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g]  = req_data[g*DATA_W +: DATA_W];
    assign zero_addr[g] = req_valid[g] && (addr_arr[g] == '0);
    assign valid_nz[g]  = req_valid[g] && (addr_arr[g] != '0);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              we1_q, we1_d;
  logic [ADDR_W-1:0] wa1_q, wa1_d;
  logic [DATA_W-1:0] wd1_q, wd1_d;
  logic              we2_q, we2_d;
  logic [ADDR_W-1:0] wa2_q, wa2_d;
  logic [DATA_W-1:0] wd2_q, wd2_d;

  // Slot selection results.
  logic              s1_vld, s2_vld;
  logic [PTR_W-1:0]  s1_idx, s2_idx;

  // Scan requesters from rr_ptr: first nonzero request takes slot 1, the next
  // one with a different destination takes slot 2.
  always_comb begin
    logic [PTR_W-1:0] cand;
    // NOTE: every variable gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    s1_vld = 1'b0;
    s1_idx = '0;
    s2_vld = 1'b0;
    s2_idx = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_ptr_q + PTR_W'(k);
      if (valid_nz[cand]) begin
        if (!s1_vld) begin
          s1_vld = 1'b1;
          s1_idx = cand;
        end else if (!s2_vld && (addr_arr[cand] != addr_arr[s1_idx])) begin
          s2_vld = 1'b1;
          s2_idx = cand;
        end
      end
    end
  end

  // Ready: register-0 sinks always, nonzero requests only when granted a slot.
  // Nothing is accepted while RST is high, so grants in a reset cycle are lost
  // and their requesters keep holding.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !RST && req_valid[i] &&
                     (zero_addr[i] ||
                      (s1_vld && (s1_idx == PTR_W'(i))) ||
                      (s2_vld && (s2_idx == PTR_W'(i))));
    end
  end

  // Next write-port contents; an unused slot drops WE and keeps WA/WD.
  always_comb begin
    we1_d = s1_vld;
    wa1_d = s1_vld ? addr_arr[s1_idx] : wa1_q;
    wd1_d = s1_vld ? data_arr[s1_idx] : wd1_q;
    we2_d = s2_vld;
    wa2_d = s2_vld ? addr_arr[s2_idx] : wa2_q;
    wd2_d = s2_vld ? data_arr[s2_idx] : wd2_q;
  end

  // Pointer moves past the last requester granted this cycle (slot 2 if used,
  // since it lies later in scan order); unchanged when nothing was granted.
  always_comb begin
    if (s2_vld) begin
      rr_ptr_d = s2_idx + PTR_W'(1);
    end else if (s1_vld) begin
      rr_ptr_d = s1_idx + PTR_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Write-port and pointer registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next-state values from the same edge.
    if (RST) begin
      rr_ptr_q <= '0;
      we1_q    <= 1'b0;
      wa1_q    <= '0;
      wd1_q    <= '0;
      we2_q    <= 1'b0;
      wa2_q    <= '0;
      wd2_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we1_q    <= we1_d;
      wa1_q    <= wa1_d;
      wd1_q    <= wd1_d;
      we2_q    <= we2_d;
      wa2_q    <= wa2_d;
      wd2_q    <= wd2_d;
    end
  end

  assign WE1 = we1_q;
  assign WA1 = wa1_q;
  assign WD1 = wd1_q;
  assign WE2 = we2_q;
  assign WA2 = wa2_q;
  assign WD2 = wd2_q;

`ifdef REGFILE_WB_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Stall counter
  // ---------------------------------------------------------------------------
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic        stall_any;

  assign stall_any = |(valid_nz & ~req_ready);

  // Count cycles where a nonzero-address request was held off; saturate.
  always_comb begin
    if (stall_any && (perf_cnt_q != 16'hFFFF)) begin
      perf_cnt_d = perf_cnt_q + 16'd1;
    end else begin
      perf_cnt_d = perf_cnt_q;
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a directed vector table walking the
// reset / two-request / full-load / collision / register-0 / mid-stream reset
// scenarios, then directed and randomized traffic checked against a
// list-based reference model of the arbitration rules.
// Build with +define+REGFILE_WB_ARB_PERF_EN to also check perf_stall_cnt.

module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREQ   = 4;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   WE1, WE2;
  logic [ADDR_W-1:0]      WA1, WA2;
  logic [DATA_W-1:0]      WD1, WD2;
  logic [15:0]            perf_stall_cnt;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREQ(NREQ)) dut (
    .CLK(CLK),
    .RST(RST),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .WE1(WE1),
    .WA1(WA1),
    .WD1(WD1),
    .WE2(WE2),
    .WA2(WA2),
    .WD2(WD2)
`ifdef REGFILE_WB_ARB_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

`ifndef REGFILE_WB_ARB_PERF_EN
  assign perf_stall_cnt = 16'h0;
`endif

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] mk_a(input logic [4:0] a3, input logic [4:0] a2,
                                       input logic [4:0] a1, input logic [4:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] mk_d(input logic [31:0] d3, input logic [31:0] d2,
                                        input logic [31:0] d1, input logic [31:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [4:0] fa(input logic [19:0] a, input int j);
    return a[j*5 +: 5];
  endfunction

  function automatic logic [31:0] fd(input logic [127:0] d, input int j);
    return d[j*32 +: 32];
  endfunction

  task automatic drive(input logic rst, input logic [3:0] v, input logic [19:0] a,
                       input logic [127:0] d);
    RST       = rst;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs for one cycle, ready expected in that cycle,
  // write ports and stall count expected after the following rising edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         rst;
    logic [3:0]   valid;
    logic [19:0]  addr;
    logic [127:0] data;
    logic [3:0]   exp_ready;
    logic         we1;
    logic [4:0]   wa1;
    logic [31:0]  wd1;
    logic         we2;
    logic [4:0]   wa2;
    logic [31:0]  wd2;
    logic [15:0]  perf;
  } vec_t;

  function automatic vec_t mk_vec(input logic rst, input logic [3:0] v, input logic [19:0] a,
                                  input logic [127:0] d, input logic [3:0] r,
                                  input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                  input logic we2, input logic [4:0] wa2, input logic [31:0] wd2,
                                  input logic [15:0] perf);
    vec_t x;
    x.rst = rst; x.valid = v; x.addr = a; x.data = d; x.exp_ready = r;
    x.we1 = we1; x.wa1 = wa1; x.wd1 = wd1;
    x.we2 = we2; x.wa2 = wa2; x.wd2 = wd2;
    x.perf = perf;
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: arbitration expressed as an ordered candidate list.
  // ---------------------------------------------------------------------------
  int          m_rr = 0;
  logic        m_we1 = 1'b0, m_we2 = 1'b0;
  logic [4:0]  m_wa1 = '0, m_wa2 = '0;
  logic [31:0] m_wd1 = '0, m_wd2 = '0;
  int          m_perf = 0;

  task automatic model_cycle(input logic rst, input logic [3:0] v, input logic [19:0] a,
                             input logic [127:0] d, output logic [3:0] exp_rdy);
    int order[$];
    int g1, g2;
    bit stall;
    exp_rdy = '0;
    g1 = -1;
    g2 = -1;
    stall = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && fa(a, i) == 5'd0) exp_rdy[i] = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (v[j] && fa(a, j) != 5'd0) order.push_back(j);
      end
      if (order.size() > 0) begin
        g1 = order[0];
        exp_rdy[g1] = 1'b1;
        for (int n = 1; n < order.size(); n++) begin
          if (g2 < 0 && fa(a, order[n]) != fa(a, g1)) begin
            g2 = order[n];
            exp_rdy[g2] = 1'b1;
          end
        end
      end
      foreach (order[n]) begin
        if (!exp_rdy[order[n]]) stall = 1'b1;
      end
    end

    drive(rst, v, a, d);
    @(negedge CLK);
    check("ready", 32'(req_ready), 32'(exp_rdy));

    if (rst) begin
      m_rr = 0; m_we1 = 1'b0; m_we2 = 1'b0;
      m_wa1 = '0; m_wa2 = '0; m_wd1 = '0; m_wd2 = '0;
      m_perf = 0;
    end else begin
      m_we1 = (g1 >= 0);
      m_we2 = (g2 >= 0);
      if (g1 >= 0) begin m_wa1 = fa(a, g1); m_wd1 = fd(d, g1); end
      if (g2 >= 0) begin m_wa2 = fa(a, g2); m_wd2 = fd(d, g2); end
      if (g2 >= 0)      m_rr = (g2 + 1) % 4;
      else if (g1 >= 0) m_rr = (g1 + 1) % 4;
      if (stall && m_perf < 65535) m_perf++;
    end

    @(posedge CLK);
    #1;
    check("we1", 32'(WE1), 32'(m_we1));
    check("wa1", 32'(WA1), 32'(m_wa1));
    check("wd1", WD1, m_wd1);
    check("we2", 32'(WE2), 32'(m_we2));
    check("wa2", 32'(WA2), 32'(m_wa2));
    check("wd2", WD2, m_wd2);
    if (WE1 && WE2) check("distinct_wa", 32'(WA1 != WA2), 32'd1);
`ifdef REGFILE_WB_ARB_PERF_EN
    check("perf", 32'(perf_stall_cnt), 32'(m_perf));
`endif
  endtask

  vec_t vecs[13];

  initial begin
    logic [3:0]   rdy;
    logic [3:0]   v;
    logic [19:0]  a;
    logic [127:0] d;

    // rst  valid    addr                      data                                      ready    we1 wa1 wd1        we2 wa2 wd2        perf
    vecs[0]  = mk_vec(1, 4'b0000, mk_a(0,0,0,0),   mk_d(0,0,0,0),                         4'b0000, 0, 0,  32'h0,  0, 0,  32'h0,  0);
    vecs[1]  = mk_vec(1, 4'b0000, mk_a(0,0,0,0),   mk_d(0,0,0,0),                         4'b0000, 0, 0,  32'h0,  0, 0,  32'h0,  0);
    vecs[2]  = mk_vec(0, 4'b0011, mk_a(0,0,4,3),   mk_d(0,0,32'h22,32'h11),               4'b0011, 1, 3,  32'h11, 1, 4,  32'h22, 0);
    vecs[3]  = mk_vec(0, 4'b1000, mk_a(8,0,0,0),   mk_d(32'h33,0,0,0),                    4'b1000, 1, 8,  32'h33, 0, 4,  32'h22, 0);
    vecs[4]  = mk_vec(0, 4'b1111, mk_a(6,5,2,1),   mk_d(32'hA3,32'hA2,32'hA1,32'hA0),     4'b0011, 1, 1,  32'hA0, 1, 2,  32'hA1, 1);
    vecs[5]  = mk_vec(0, 4'b1100, mk_a(6,5,0,0),   mk_d(32'hA3,32'hA2,0,0),               4'b1100, 1, 5,  32'hA2, 1, 6,  32'hA3, 1);
    vecs[6]  = mk_vec(0, 4'b0001, mk_a(0,0,0,10),  mk_d(0,0,0,32'hB0),                    4'b0001, 1, 10, 32'hB0, 0, 6,  32'hA3, 1);
    vecs[7]  = mk_vec(0, 4'b0110, mk_a(0,7,7,0),   mk_d(0,32'hC2,32'hC1,0),               4'b0010, 1, 7,  32'hC1, 0, 6,  32'hA3, 2);
    vecs[8]  = mk_vec(0, 4'b0100, mk_a(0,7,0,0),   mk_d(0,32'hC2,0,0),                    4'b0100, 1, 7,  32'hC2, 0, 6,  32'hA3, 2);
    vecs[9]  = mk_vec(0, 4'b1001, mk_a(0,0,0,9),   mk_d(32'hD3,0,0,32'hD0),               4'b1001, 1, 9,  32'hD0, 0, 6,  32'hA3, 2);
    vecs[10] = mk_vec(1, 4'b1111, mk_a(14,13,12,11), mk_d(32'hE3,32'hE2,32'hE1,32'hE0),   4'b0000, 0, 0,  32'h0,  0, 0,  32'h0,  0);
    vecs[11] = mk_vec(0, 4'b1111, mk_a(14,13,12,11), mk_d(32'hE3,32'hE2,32'hE1,32'hE0),   4'b0011, 1, 11, 32'hE0, 1, 12, 32'hE1, 1);
    vecs[12] = mk_vec(0, 4'b1100, mk_a(14,13,0,0), mk_d(32'hE3,32'hE2,0,0),               4'b1100, 1, 13, 32'hE2, 1, 14, 32'hE3, 1);

    @(posedge CLK);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].addr, vecs[i].data);
      @(negedge CLK);
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      @(posedge CLK);
      #1;
      check($sformatf("v%0d_we1", i), 32'(WE1), 32'(vecs[i].we1));
      check($sformatf("v%0d_wa1", i), 32'(WA1), 32'(vecs[i].wa1));
      check($sformatf("v%0d_wd1", i), WD1, vecs[i].wd1);
      check($sformatf("v%0d_we2", i), 32'(WE2), 32'(vecs[i].we2));
      check($sformatf("v%0d_wa2", i), 32'(WA2), 32'(vecs[i].wa2));
      check($sformatf("v%0d_wd2", i), WD2, vecs[i].wd2);
`ifdef REGFILE_WB_ARB_PERF_EN
      check($sformatf("v%0d_perf", i), 32'(perf_stall_cnt), 32'(vecs[i].perf));
`endif
    end

    // Re-synchronise the model with a reset cycle, then directed hot spot:
    // all four requesters target the same register, one grant per cycle.
    model_cycle(1'b1, 4'b0000, '0, '0, rdy);
    v = 4'b1111;
    a = mk_a(20, 20, 20, 20);
    d = mk_d(32'h4444, 32'h3333, 32'h2222, 32'h1111);
    for (int n = 0; n < 8 && v != 4'b0000; n++) begin
      model_cycle(1'b0, v, a, d, rdy);
      v = v & ~rdy;
    end
    check("hot_spot_drained", 32'(v), 32'd0);

    // Mixed hand sequence: r0 sinks alongside a collision pair.
    v = 4'b1111;
    a = mk_a(0, 17, 17, 0);
    d = mk_d(32'h5003, 32'h5002, 32'h5001, 32'h5000);
    for (int n = 0; n < 4 && v != 4'b0000; n++) begin
      model_cycle(1'b0, v, a, d, rdy);
      v = v & ~rdy;
    end

    // Randomized traffic with holding requesters and occasional reset.
    v = 4'b0000;
    a = '0;
    d = '0;
    for (int n = 0; n < 400; n++) begin
      logic rst;
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && $urandom_range(0, 99) < 60) begin
          v[i] = 1'b1;
          a[i*5 +: 5]  = 5'($urandom_range(0, 7));
          d[i*32 +: 32] = $urandom;
        end
      end
      rst = ($urandom_range(0, 49) == 0);
      model_cycle(rst, v, a, d, rdy);
      v = v & ~rdy;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
